// File: rtl/ex_stage.sv
// ex_stage: execute stage of the five-stage MIPS pipeline.
//   Registers the ID->EX bus and evaluates the ALU. Drives the data SRAM
//   request and forwards its result to ID. Owns HI/LO and a 32-iteration
//   restoring divider for DIV/DIVU, which raises stallreq while it works.
//
// Ports
//   clk, rst         clock, synchronous active-high reset
//   stall            per-stage stall vector (bit 2 ID/EX, bit 3 EX/MEM)
//   id_to_ex_bus     decoded instruction and operands from ID
//   ex_to_mem_bus    {pc, ram_en, ram_wen, sel_rf_res, rf_we, rf_waddr, ex_result}
//   ex_to_id_bus     {rf_we, rf_waddr, ex_result} forwarding path
//   ex_is_load       EX holds a load (ex_result is an address only)
//   data_sram_*      data SRAM request
//   stallreq         divider busy, hold the front of the pipeline
//
// Divider FSM
//   state | meaning
//   IDLE  | waiting for DIV/DIVU; latches operand magnitudes and signs
//   BUSY  | one shift-subtract iteration per cycle, counter 0..31
//   DONE  | apply signs, write HI/LO at the closing edge
module ex_stage #(
  parameter int ID_TO_EX_WD  = 159,
  parameter int EX_TO_MEM_WD = 76,
  parameter int StallBus     = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [StallBus-1:0]     stall,
  input  logic [ID_TO_EX_WD-1:0]  id_to_ex_bus,
  output logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  output logic [37:0]             ex_to_id_bus,
  output logic                    ex_is_load,
  output logic                    data_sram_en,
  output logic [3:0]              data_sram_wen,
  output logic [31:0]             data_sram_addr,
  output logic [31:0]             data_sram_wdata,
  output logic                    stallreq
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_t;

  logic [ID_TO_EX_WD-1:0] ex_bus_r;

  // A held EX register keeps its instruction; anything else means it leaves.
  logic ex_hold, ex_clear;
  assign ex_hold  = stall[2] & stall[3];
  assign ex_clear = stall[2] & ~stall[3];

  always_ff @(posedge clk) begin
    if (rst)            ex_bus_r <= '0;
    else if (ex_clear)  ex_bus_r <= '0;
    else if (!stall[2]) ex_bus_r <= id_to_ex_bus;
  end

  logic [31:0] pc, inst, rdata1, rdata2;
  logic [11:0] alu_op;
  logic [2:0]  sel_src1;
  logic [3:0]  sel_src2;
  logic        ram_en, rf_we, sel_rf_res;
  logic [3:0]  ram_wen;
  logic [4:0]  rf_waddr;

  assign pc         = ex_bus_r[158:127];
  assign inst       = ex_bus_r[126:95];
  assign alu_op     = ex_bus_r[94:83];
  assign sel_src1   = ex_bus_r[82:80];
  assign sel_src2   = ex_bus_r[79:76];
  assign ram_en     = ex_bus_r[75];
  assign ram_wen    = ex_bus_r[74:71];
  assign rf_we      = ex_bus_r[70];
  assign rf_waddr   = ex_bus_r[69:65];
  assign sel_rf_res = ex_bus_r[64];
  assign rdata1     = ex_bus_r[63:32];
  assign rdata2     = ex_bus_r[31:0];

  // Operand muxes: AND-OR over the one-hot selects, zero when none is set.
  logic [31:0] src1, src2;
  assign src1 = ({32{sel_src1[0]}} & rdata1)
              | ({32{sel_src1[1]}} & pc)
              | ({32{sel_src1[2]}} & {27'd0, inst[10:6]});
  assign src2 = ({32{sel_src2[0]}} & rdata2)
              | ({32{sel_src2[1]}} & {{16{inst[15]}}, inst[15:0]})
              | ({32{sel_src2[2]}} & 32'd8)
              | ({32{sel_src2[3]}} & {16'd0, inst[15:0]});

  logic [31:0] add_res, sub_res, slt_res, sltu_res, sll_res, srl_res, sra_res, lui_res;
  logic [31:0] alu_res;
  assign add_res  = src1 + src2;
  assign sub_res  = src1 - src2;
  assign slt_res  = {31'd0, $signed(src1) < $signed(src2)};
  assign sltu_res = {31'd0, src1 < src2};
  assign sll_res  = src2 << src1[4:0];
  assign srl_res  = src2 >> src1[4:0];
  assign sra_res  = $signed(src2) >>> src1[4:0];
  assign lui_res  = {src2[15:0], 16'h0};

  assign alu_res = ({32{alu_op[11]}} & add_res)
                 | ({32{alu_op[10]}} & sub_res)
                 | ({32{alu_op[9]}}  & slt_res)
                 | ({32{alu_op[8]}}  & sltu_res)
                 | ({32{alu_op[7]}}  & (src1 & src2))
                 | ({32{alu_op[6]}}  & ~(src1 | src2))
                 | ({32{alu_op[5]}}  & (src1 | src2))
                 | ({32{alu_op[4]}}  & (src1 ^ src2))
                 | ({32{alu_op[3]}}  & sll_res)
                 | ({32{alu_op[2]}}  & srl_res)
                 | ({32{alu_op[1]}}  & sra_res)
                 | ({32{alu_op[0]}}  & lui_res);

  logic special, is_div, is_divu, is_mfhi, is_mflo, is_mthi, is_mtlo, any_div;
  assign special = (inst[31:26] == 6'b000000);
  assign is_div  = special && (inst[5:0] == 6'b011010);
  assign is_divu = special && (inst[5:0] == 6'b011011);
  assign is_mfhi = special && (inst[5:0] == 6'b010000);
  assign is_mflo = special && (inst[5:0] == 6'b010010);
  assign is_mthi = special && (inst[5:0] == 6'b010001);
  assign is_mtlo = special && (inst[5:0] == 6'b010011);
  assign any_div = is_div | is_divu;

  logic [31:0] hi, lo, ex_result;
  assign ex_result = is_mfhi ? hi : (is_mflo ? lo : alu_res);

  div_state_t  div_state, div_next;
  logic [5:0]  div_cnt;
  logic [31:0] div_q, div_r, div_d;
  logic        neg_q, neg_r, div_zero, done_latched;
  logic        div_start;

  // done_latched keeps a finished divide that is still held in EX from
  // starting over.
  assign div_start = any_div && !done_latched;
  assign stallreq  = any_div && !done_latched && (div_state != DONE);

  always_ff @(posedge clk) begin
    if (rst) div_state <= IDLE;
    else     div_state <= div_next;
  end

  always_comb begin
    div_next = div_state;
    case (div_state)
      IDLE:    if (div_start) div_next = BUSY;
      BUSY:    if (div_cnt == 6'd31) div_next = DONE;
      DONE:    div_next = IDLE;
      default: div_next = IDLE;
    endcase
  end

  // Restoring step: shift the next dividend bit into the partial remainder
  // and subtract the divisor when it fits. 34 bits keep the borrow clean.
  logic [32:0] r_shift;
  logic [33:0] r_diff;
  logic        r_fits;
  assign r_shift = {div_r, div_q[31]};
  assign r_diff  = {1'b0, r_shift} - {2'b00, div_d};
  assign r_fits  = ~r_diff[33];

  logic [31:0] dvd_abs, dvs_abs;
  assign dvd_abs = (is_div && rdata1[31]) ? (~rdata1 + 32'd1) : rdata1;
  assign dvs_abs = (is_div && rdata2[31]) ? (~rdata2 + 32'd1) : rdata2;

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt  <= '0;
      div_q    <= '0;
      div_r    <= '0;
      div_d    <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      case (div_state)
        IDLE: if (div_start) begin
          div_q    <= dvd_abs;
          div_r    <= '0;
          div_d    <= dvs_abs;
          neg_q    <= is_div && (rdata1[31] ^ rdata2[31]);
          neg_r    <= is_div && rdata1[31];
          div_zero <= (rdata2 == 32'd0);
          div_cnt  <= '0;
        end
        BUSY: begin
          div_q   <= {div_q[30:0], r_fits};
          div_r   <= r_fits ? r_diff[31:0] : r_shift[31:0];
          div_cnt <= div_cnt + 6'd1;
        end
        default: ;
      endcase
    end
  end

  // With a zero divisor the remainder path already reproduces the dividend;
  // only the quotient needs forcing to all ones.
  logic [31:0] quo_final, rem_final;
  assign quo_final = div_zero ? 32'hFFFF_FFFF : (neg_q ? (~div_q + 32'd1) : div_q);
  assign rem_final = neg_r ? (~div_r + 32'd1) : div_r;

  always_ff @(posedge clk) begin
    if (rst) done_latched <= 1'b0;
    else if (!ex_hold) done_latched <= 1'b0;
    else if (div_state == DONE) done_latched <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi <= '0;
      lo <= '0;
    end else if (div_state == DONE) begin
      hi <= rem_final;
      lo <= quo_final;
    end else if (!ex_hold) begin
      if (is_mthi) hi <= rdata1;
      if (is_mtlo) lo <= rdata1;
    end
  end

  assign data_sram_en    = ram_en;
  assign data_sram_wen   = ram_wen;
  assign data_sram_addr  = alu_res;
  assign data_sram_wdata = rdata2;

  assign ex_is_load    = sel_rf_res;
  assign ex_to_mem_bus = {pc, ram_en, ram_wen, sel_rf_res, rf_we, rf_waddr, ex_result};
  assign ex_to_id_bus  = {rf_we, rf_waddr, ex_result};

endmodule

// File: tb/tb_ex_stage.sv
module tb_ex_stage;

  logic         clk = 1'b0;
  logic         rst;
  logic [5:0]   stall;
  logic [158:0] id_to_ex_bus;
  logic [75:0]  ex_to_mem_bus;
  logic [37:0]  ex_to_id_bus;
  logic         ex_is_load;
  logic         data_sram_en;
  logic [3:0]   data_sram_wen;
  logic [31:0]  data_sram_addr;
  logic [31:0]  data_sram_wdata;
  logic         stallreq;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [11:0] OP_ADD = 12'h800, OP_SUB = 12'h400, OP_SLT = 12'h200,
                          OP_SLTU = 12'h100, OP_NOR = 12'h040, OP_SRL = 12'h004,
                          OP_SRA = 12'h002, OP_LUI = 12'h001;
  localparam logic [31:0] I_DIV  = 32'h0000_001A, I_DIVU = 32'h0000_001B,
                          I_MFHI = 32'h0000_0010, I_MFLO = 32'h0000_0012,
                          I_MTHI = 32'h0000_0011;

  ex_stage dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .id_to_ex_bus    (id_to_ex_bus),
    .ex_to_mem_bus   (ex_to_mem_bus),
    .ex_to_id_bus    (ex_to_id_bus),
    .ex_is_load      (ex_is_load),
    .data_sram_en    (data_sram_en),
    .data_sram_wen   (data_sram_wen),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata),
    .stallreq        (stallreq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [75:0] got, input logic [75:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [158:0] mk(input logic [31:0] pc, input logic [31:0] inst,
                                      input logic [11:0] op, input logic [2:0] s1,
                                      input logic [3:0] s2, input logic ram_en,
                                      input logic [3:0] wen, input logic rf_we,
                                      input logic [4:0] wa, input logic sel_res,
                                      input logic [31:0] r1, input logic [31:0] r2);
    return {pc, inst, op, s1, s2, ram_en, wen, rf_we, wa, sel_res, r1, r2};
  endfunction

  task automatic alu_vec(input string tag, input logic [31:0] inst, input logic [11:0] op,
                         input logic [2:0] s1, input logic [3:0] s2,
                         input logic [31:0] r1, input logic [31:0] r2,
                         input logic [31:0] exp);
    id_to_ex_bus = mk(32'hBFC0_0100, inst, op, s1, s2, 1'b0, 4'h0, 1'b1, 5'd8, 1'b0, r1, r2);
    stall = 6'd0;
    tick();
    check(tag, {38'd0, ex_to_id_bus}, {38'd0, 1'b1, 5'd8, exp});
  endtask

  // Loads a divide, answers stallreq with a front-of-pipeline stall and
  // counts the stalled cycles; returns during the DONE cycle.
  task automatic run_div(input logic [31:0] inst, input logic [31:0] r1,
                         input logic [31:0] r2, output int cnt);
    id_to_ex_bus = mk(32'hBFC0_0200, inst, 12'h0, 3'b000, 4'b0000, 1'b0, 4'h0, 1'b0,
                      5'd0, 1'b0, r1, r2);
    stall = 6'd0;
    tick();
    id_to_ex_bus = mk(32'hBFC0_0204, I_MFLO, 12'h0, 3'b000, 4'b0000, 1'b0, 4'h0, 1'b1,
                      5'd9, 1'b0, 32'd0, 32'd0);
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      if (!stallreq) break;
      cnt++;
      stall = 6'b001111;
      tick();
    end
  endtask

  task automatic read_hilo(input string tag, input logic [31:0] inst, input logic [31:0] exp);
    id_to_ex_bus = mk(32'hBFC0_0300, inst, 12'h0, 3'b000, 4'b0000, 1'b0, 4'h0, 1'b1,
                      5'd10, 1'b0, 32'd0, 32'd0);
    stall = 6'd0;
    tick();
    check(tag, {44'd0, ex_to_id_bus[31:0]}, {44'd0, exp});
  endtask

  logic [158:0] addiu_bus;
  logic [75:0]  addiu_mem;
  int           cnt;

  initial begin
    rst = 1'b1;
    stall = 6'd0;
    id_to_ex_bus = '0;
    tick();
    tick();
    check("rst_mem_bus", ex_to_mem_bus, 76'd0);
    check("rst_id_bus", {38'd0, ex_to_id_bus}, 76'd0);
    check("rst_stallreq", {75'd0, stallreq}, 76'd0);
    check("rst_sram", {39'd0, data_sram_en, data_sram_wen, data_sram_addr}, 76'd0);
    check("rst_is_load", {75'd0, ex_is_load}, 76'd0);
    rst = 1'b0;

    // ADDIU $2, $1, -1 with $1 = 5
    addiu_bus = mk(32'hBFC0_0010, 32'h2422_FFFF, OP_ADD, 3'b001, 4'b0010, 1'b0, 4'h0,
                   1'b1, 5'd2, 1'b0, 32'd5, 32'd0);
    addiu_mem = {32'hBFC0_0010, 1'b0, 4'h0, 1'b0, 1'b1, 5'd2, 32'd4};
    id_to_ex_bus = addiu_bus;
    tick();
    check("addiu_fwd", {38'd0, ex_to_id_bus}, {38'd0, 1'b1, 5'd2, 32'd4});
    check("addiu_mem", ex_to_mem_bus, addiu_mem);

    // LW $3, 8($1) with $1 = 0x1000
    id_to_ex_bus = mk(32'hBFC0_0014, 32'h8C23_0008, OP_ADD, 3'b001, 4'b0010, 1'b1, 4'h0,
                      1'b1, 5'd3, 1'b1, 32'h0000_1000, 32'd0);
    tick();
    check("lw_sram", {39'd0, data_sram_en, data_sram_wen, data_sram_addr},
          {39'd0, 1'b1, 4'h0, 32'h0000_1008});
    check("lw_is_load", {75'd0, ex_is_load}, {75'd0, 1'b1});

    // SW $2, -4($1)
    id_to_ex_bus = mk(32'hBFC0_0018, 32'hAC22_FFFC, OP_ADD, 3'b001, 4'b0010, 1'b1, 4'hF,
                      1'b0, 5'd0, 1'b0, 32'h0000_2000, 32'hCAFE_F00D);
    tick();
    check("sw_sram", {7'd0, data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata},
          {7'd0, 1'b1, 4'hF, 32'h0000_1FFC, 32'hCAFE_F00D});

    alu_vec("sub",  32'h0, OP_SUB,  3'b001, 4'b0001, 32'd3, 32'd5, 32'hFFFF_FFFE);
    alu_vec("slt",  32'h0, OP_SLT,  3'b001, 4'b0001, 32'hFFFF_FFFF, 32'd1, 32'd1);
    alu_vec("sltu", 32'h0, OP_SLTU, 3'b001, 4'b0001, 32'hFFFF_FFFF, 32'd1, 32'd0);
    alu_vec("nor",  32'h0, OP_NOR,  3'b001, 4'b0001, 32'hF0F0_F0F0, 32'h0F0F_0000, 32'h0000_0F0F);
    alu_vec("sra",  32'h0000_0103, OP_SRA, 3'b100, 4'b0001, 32'd0, 32'h8000_0000, 32'hF800_0000);
    alu_vec("srl",  32'h0000_0102, OP_SRL, 3'b100, 4'b0001, 32'd0, 32'h8000_0000, 32'h0800_0000);
    alu_vec("lui",  32'h3C08_1234, OP_LUI, 3'b000, 4'b1000, 32'd0, 32'd0, 32'h1234_0000);
    // pc + 8 link address: pc is 0xBFC00100 inside alu_vec
    alu_vec("link", 32'h0C00_0000, OP_ADD, 3'b010, 4'b0100, 32'd0, 32'd0, 32'hBFC0_0108);

    // MTHI then MFHI
    id_to_ex_bus = mk(32'hBFC0_0020, I_MTHI, 12'h0, 3'b000, 4'b0000, 1'b0, 4'h0, 1'b0,
                      5'd0, 1'b0, 32'hDEAD_BEEF, 32'd0);
    tick();
    read_hilo("mthi_mfhi", I_MFHI, 32'hDEAD_BEEF);

    // DIV -7 / 2
    run_div(I_DIV, 32'hFFFF_FFF9, 32'd2, cnt);
    check("div_stall_cycles", 76'(cnt), 76'd33);
    stall = 6'd0;
    tick();
    check("div_mflo_behind", {44'd0, ex_to_id_bus[31:0]}, {44'd0, 32'hFFFF_FFFD});
    read_hilo("div_hi", I_MFHI, 32'hFFFF_FFFF);
    read_hilo("div_lo", I_MFLO, 32'hFFFF_FFFD);

    // DIVU 0xFFFFFFFF / 0
    run_div(I_DIVU, 32'hFFFF_FFFF, 32'd0, cnt);
    check("divu0_stall_cycles", 76'(cnt), 76'd33);
    stall = 6'd0;
    tick();
    read_hilo("divu0_hi", I_MFHI, 32'hFFFF_FFFF);
    read_hilo("divu0_lo", I_MFLO, 32'hFFFF_FFFF);

    // Reset while BUSY with counter = 10
    id_to_ex_bus = mk(32'hBFC0_0400, I_DIV, 12'h0, 3'b000, 4'b0000, 1'b0, 4'h0, 1'b0,
                      5'd0, 1'b0, 32'd50, 32'd3);
    stall = 6'd0;
    tick();
    stall = 6'b001111;
    for (int i = 0; i < 11; i++) tick();
    check("busy_stallreq", {75'd0, stallreq}, {75'd0, 1'b1});
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_busy_stallreq", {75'd0, stallreq}, 76'd0);
    read_hilo("rst_busy_hi", I_MFHI, 32'd0);
    read_hilo("rst_busy_lo", I_MFLO, 32'd0);

    // Fresh DIV 100 / 7, then held in EX after DONE by a downstream stall
    run_div(I_DIV, 32'd100, 32'd7, cnt);
    check("div100_stall_cycles", 76'(cnt), 76'd33);
    stall = 6'b001111;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("held_no_restart", {75'd0, stallreq}, 76'd0);
    end
    stall = 6'd0;
    tick();
    read_hilo("div100_hi", I_MFHI, 32'd2);
    read_hilo("div100_lo", I_MFLO, 32'd14);

    // Bubble and hold
    id_to_ex_bus = addiu_bus;
    stall = 6'd0;
    tick();
    stall = 6'b000111;
    tick();
    check("bubble_mem_bus", ex_to_mem_bus, 76'd0);
    check("bubble_id_bus", {38'd0, ex_to_id_bus}, 76'd0);
    id_to_ex_bus = addiu_bus;
    stall = 6'd0;
    tick();
    id_to_ex_bus = mk(32'h1111_1111, 32'h2422_0001, OP_SUB, 3'b001, 4'b0001, 1'b1, 4'h3,
                      1'b0, 5'd7, 1'b1, 32'd9, 32'd9);
    stall = 6'b001111;
    tick();
    tick();
    check("hold_mem_bus", ex_to_mem_bus, addiu_mem);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
